// File: rtl/bg_tile_renderer.sv
// rtl/bg_tile_renderer.sv - scrolling 8x8 tile background renderer, 5-stage pixel pipeline
// Tile map is 64x32 of 4-bit indices; scroll updates are latched on the frame-start pulse only.
module bg_tile_renderer #(
  parameter int X_ORIGIN = 63,
  parameter int Y_ORIGIN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  CounterX,
  input  logic [9:0]  CounterY,
  input  logic        inDisplayArea,
  input  logic        vga_v_sync,
  input  logic        scroll_valid,
  output logic        scroll_ready,
  input  logic [8:0]  scroll_x,
  input  logic [7:0]  scroll_y,
  input  logic        map_we,
  input  logic [10:0] map_waddr,
  input  logic [3:0]  map_wdata,
  output logic [9:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        de_out
);

  logic [3:0] tile_map [0:2047];

  logic       pending_q, pending_d;
  logic [8:0] pending_x_q, pending_x_d;
  logic [7:0] pending_y_q, pending_y_d;
  logic [8:0] scroll_x_act_q, scroll_x_act_d;
  logic [7:0] scroll_y_act_q, scroll_y_act_d;

  logic [8:0] wx_q, wx_d;
  logic [7:0] wy_q, wy_d;
  logic       de1_q, de1_d;
  logic [3:0] tile_q, tile_d;
  logic [2:0] fine_x_q, fine_x_d;
  logic [2:0] fine_y_q, fine_y_d;
  logic       de2_q, de2_d;
  logic [9:0] rom_addr_q, rom_addr_d;
  logic       de3_q, de3_d;
  logic       de4_q, de4_d;
  logic [2:0] vga_r_q, vga_r_d;
  logic [2:0] vga_g_q, vga_g_d;
  logic [1:0] vga_b_q, vga_b_d;
  logic       de_out_q, de_out_d;

  logic [9:0]  sx;
  logic [9:0]  sy;
  logic [10:0] map_raddr;
  logic        scroll_accept;
  logic        scroll_load;
  logic        unused_coord_bits;

  assign unused_coord_bits = ^{sx[9], sy[9:8]};

  always_comb begin
    sx            = CounterX - 10'(X_ORIGIN);
    sy            = CounterY - 10'(Y_ORIGIN);
    scroll_accept = scroll_valid && !pending_q;
    scroll_load   = vga_v_sync && pending_q;

    pending_d      = pending_q;
    pending_x_d    = pending_x_q;
    pending_y_d    = pending_y_q;
    scroll_x_act_d = scroll_x_act_q;
    scroll_y_act_d = scroll_y_act_q;

    // Load only from a request already pending when the vsync cycle began,
    // so a request arriving with vsync waits for the next frame.
    if (scroll_load) begin
      scroll_x_act_d = pending_x_q;
      scroll_y_act_d = pending_y_q;
      pending_d      = 1'b0;
    end else if (scroll_accept) begin
      pending_x_d = scroll_x;
      pending_y_d = scroll_y;
      pending_d   = 1'b1;
    end

    wx_d  = sx[8:0] + scroll_x_act_q;
    wy_d  = sy[7:0] + scroll_y_act_q;
    de1_d = inDisplayArea;

    map_raddr = {wy_q[7:3], wx_q[8:3]};
    tile_d    = tile_map[map_raddr];
    fine_x_d  = wx_q[2:0];
    fine_y_d  = wy_q[2:0];
    de2_d     = de1_q;

    rom_addr_d = {tile_q, fine_y_q, fine_x_q};
    de3_d      = de2_q;

    de4_d = de3_q;

    vga_r_d  = 3'd0;
    vga_g_d  = 3'd0;
    vga_b_d  = 2'd0;
    de_out_d = de4_q;
    if (de4_q) begin
      vga_r_d = rom_data[7:5];
      vga_g_d = rom_data[4:2];
      vga_b_d = rom_data[1:0];
    end
  end

  // Read-before-write: a same-edge read of the written address sees the old tile.
  always_ff @(posedge clk) begin
    if (map_we) tile_map[map_waddr] <= map_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= 1'b0;
      pending_x_q    <= 9'd0;
      pending_y_q    <= 8'd0;
      scroll_x_act_q <= 9'd0;
      scroll_y_act_q <= 8'd0;
      wx_q           <= 9'd0;
      wy_q           <= 8'd0;
      de1_q          <= 1'b0;
      tile_q         <= 4'd0;
      fine_x_q       <= 3'd0;
      fine_y_q       <= 3'd0;
      de2_q          <= 1'b0;
      rom_addr_q     <= 10'd0;
      de3_q          <= 1'b0;
      de4_q          <= 1'b0;
      vga_r_q        <= 3'd0;
      vga_g_q        <= 3'd0;
      vga_b_q        <= 2'd0;
      de_out_q       <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      pending_x_q    <= pending_x_d;
      pending_y_q    <= pending_y_d;
      scroll_x_act_q <= scroll_x_act_d;
      scroll_y_act_q <= scroll_y_act_d;
      wx_q           <= wx_d;
      wy_q           <= wy_d;
      de1_q          <= de1_d;
      tile_q         <= tile_d;
      fine_x_q       <= fine_x_d;
      fine_y_q       <= fine_y_d;
      de2_q          <= de2_d;
      rom_addr_q     <= rom_addr_d;
      de3_q          <= de3_d;
      de4_q          <= de4_d;
      vga_r_q        <= vga_r_d;
      vga_g_q        <= vga_g_d;
      vga_b_q        <= vga_b_d;
      de_out_q       <= de_out_d;
    end
  end

  assign scroll_ready = !pending_q && !reset;
  assign rom_addr     = rom_addr_q;
  assign vga_r        = vga_r_q;
  assign vga_g        = vga_g_q;
  assign vga_b        = vga_b_q;
  assign de_out       = de_out_q;

endmodule

// File: tb/tb_bg_tile_renderer.sv
// tb/tb_bg_tile_renderer.sv - self-checking bench for bg_tile_renderer
module tb_bg_tile_renderer;
  localparam int X0 = 63;
  localparam int Y0 = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  CounterX;
  logic [9:0]  CounterY;
  logic        inDisplayArea;
  logic        vga_v_sync;
  logic        scroll_valid;
  logic        scroll_ready;
  logic [8:0]  scroll_x;
  logic [7:0]  scroll_y;
  logic        map_we;
  logic [10:0] map_waddr;
  logic [3:0]  map_wdata;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;
  logic        de_out;

  bg_tile_renderer #(.X_ORIGIN(X0), .Y_ORIGIN(Y0)) dut (
    .clk(clk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .inDisplayArea(inDisplayArea), .vga_v_sync(vga_v_sync),
    .scroll_valid(scroll_valid), .scroll_ready(scroll_ready),
    .scroll_x(scroll_x), .scroll_y(scroll_y),
    .map_we(map_we), .map_waddr(map_waddr), .map_wdata(map_wdata),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .de_out(de_out)
  );

  always #5 clk = ~clk;

  logic rom_force_ff = 1'b0;
  always @(posedge clk) rom_data <= rom_force_ff ? 8'hFF : rom_addr[7:0];

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] map_m [2048];
  int act_x = 0;
  int act_y = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] exp_addr(input int cx, input int cy);
    int wx, wy;
    logic [8:0] bx;
    logic [7:0] by;
    wx = (cx - X0 + 1024 + act_x) % 512;
    wy = (cy - Y0 + 1024 + act_y) % 256;
    bx = wx[8:0];
    by = wy[7:0];
    return {map_m[(wy / 8) * 64 + (wx / 8)], by[2:0], bx[2:0]};
  endfunction

  task automatic apply_scroll(input int x, input int y);
    scroll_valid = 1'b1; scroll_x = 9'(x); scroll_y = 8'(y);
    step;
    scroll_valid = 1'b0; vga_v_sync = 1'b1;
    step;
    vga_v_sync = 1'b0;
    act_x = x; act_y = y;
  endtask

  task automatic fill_map;
    for (int a = 0; a < 2048; a++) begin
      map_m[a] = 4'($urandom_range(0, 15));
      if (a == 0) map_m[a] = 4'd5;
      if (a == 1) map_m[a] = 4'hA;
      if (a == 2047) map_m[a] = 4'd3;
      map_we = 1'b1; map_waddr = 11'(a); map_wdata = map_m[a];
      step;
    end
    map_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; inDisplayArea = 1'b1;
    #1;
    n_vec++;
    if (scroll_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_comb: got %b expected 0", scroll_ready); end
    for (int i = 0; i < 3; i++) begin
      step;
      n_vec++;
      if ({vga_r, vga_g, vga_b, de_out, rom_addr, scroll_ready} !== 19'd0) begin
        n_err++; $display("FAIL reset_outputs: got %h expected 0", {vga_r, vga_g, vga_b, de_out, rom_addr, scroll_ready});
      end
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (scroll_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b expected 1", scroll_ready); end
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) inDisplayArea = 1'b0;
      step;
      n_vec++;
      if (de_out !== (i == 5)) begin n_err++; $display("FAIL release_de step %0d: got %b expected %b", i, de_out, i == 5); end
    end
  endtask

  task automatic test_latency;
    logic [9:0] ea;
    ea = exp_addr(63, 16);
    CounterX = 10'd63; CounterY = 10'd16; inDisplayArea = 1'b1;
    step;
    inDisplayArea = 1'b0;
    step;
    step;
    n_vec++;
    if (rom_addr !== 10'h140 || rom_addr !== ea) begin n_err++; $display("FAIL latency_rom_addr: got %h expected 140", rom_addr); end
    step;
    n_vec++;
    if (de_out !== 1'b0) begin n_err++; $display("FAIL latency_de_early: got %b expected 0", de_out); end
    step;
    n_vec++;
    if (de_out !== 1'b1 || {vga_r, vga_g, vga_b} !== 8'h40) begin
      n_err++; $display("FAIL latency_pixel: got de %b col %h expected de 1 col 40", de_out, {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_blank;
    rom_force_ff = 1'b1; inDisplayArea = 1'b0;
    for (int i = 0; i < 6; i++) begin
      CounterX = 10'($urandom_range(0, 1023)); CounterY = 10'($urandom_range(0, 1023));
      step;
      n_vec++;
      if ({vga_r, vga_g, vga_b, de_out} !== 9'd0) begin
        n_err++; $display("FAIL blank_out: got %h expected 0", {vga_r, vga_g, vga_b, de_out});
      end
    end
    inDisplayArea = 1'b1;
    step;
    inDisplayArea = 1'b0;
    repeat (4) step;
    n_vec++;
    if ({vga_r, vga_g, vga_b, de_out} !== 9'h1FF) begin
      n_err++; $display("FAIL visible_ff: got %h expected 1ff", {vga_r, vga_g, vga_b, de_out});
    end
    rom_force_ff = 1'b0;
  endtask

  task automatic test_handshake;
    CounterX = 10'd63; CounterY = 10'd16; inDisplayArea = 1'b1;
    scroll_valid = 1'b1; scroll_x = 9'd8; scroll_y = 8'd0;
    #1;
    n_vec++;
    if (scroll_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready_idle: got %b expected 1", scroll_ready); end
    step;
    scroll_x = 9'd100; scroll_y = 8'd77;
    n_vec++;
    if (scroll_ready !== 1'b0) begin n_err++; $display("FAIL hs_ready_pending: got %b expected 0", scroll_ready); end
    repeat (3) step;
    scroll_valid = 1'b0;
    step;
    n_vec++;
    if (rom_addr !== exp_addr(63, 16)) begin n_err++; $display("FAIL hs_unchanged: got %h expected %h", rom_addr, exp_addr(63, 16)); end
    vga_v_sync = 1'b1;
    step;
    vga_v_sync = 1'b0;
    act_x = 8; act_y = 0;
    n_vec++;
    if (scroll_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready_after_vsync: got %b expected 1", scroll_ready); end
    repeat (4) step;
    n_vec++;
    if (rom_addr !== exp_addr(63, 16)) begin n_err++; $display("FAIL hs_applied: got %h expected %h", rom_addr, exp_addr(63, 16)); end
  endtask

  task automatic test_vsync_coincident;
    int nx, ny;
    nx = $urandom_range(0, 511); ny = $urandom_range(0, 255);
    CounterX = 10'($urandom_range(0, 1023)); CounterY = 10'($urandom_range(0, 1023));
    scroll_valid = 1'b1; scroll_x = 9'(nx); scroll_y = 8'(ny); vga_v_sync = 1'b1;
    step;
    scroll_valid = 1'b0; vga_v_sync = 1'b0;
    n_vec++;
    if (scroll_ready !== 1'b0) begin n_err++; $display("FAIL vc_accepted: got %b expected 0", scroll_ready); end
    repeat (4) step;
    n_vec++;
    if (rom_addr !== exp_addr(int'(CounterX), int'(CounterY))) begin
      n_err++; $display("FAIL vc_not_applied: got %h expected %h", rom_addr, exp_addr(int'(CounterX), int'(CounterY)));
    end
    vga_v_sync = 1'b1;
    step;
    vga_v_sync = 1'b0;
    act_x = nx; act_y = ny;
    repeat (4) step;
    n_vec++;
    if (rom_addr !== exp_addr(int'(CounterX), int'(CounterY))) begin
      n_err++; $display("FAIL vc_applied: got %h expected %h", rom_addr, exp_addr(int'(CounterX), int'(CounterY)));
    end
  endtask

  task automatic test_wrap;
    apply_scroll(511, 255);
    CounterX = 10'(X0 + 1); CounterY = 10'(Y0 + 1); inDisplayArea = 1'b1;
    repeat (3) step;
    n_vec++;
    if (rom_addr !== {map_m[0], 6'd0} || rom_addr !== exp_addr(X0 + 1, Y0 + 1)) begin
      n_err++; $display("FAIL wrap_addr: got %h expected %h", rom_addr, {map_m[0], 6'd0});
    end
  endtask

  task automatic test_random;
    logic [9:0] ha [256];
    logic       hd [256];
    int cx, cy;
    logic de;
    for (int s = 0; s < 3; s++) begin
      apply_scroll($urandom_range(0, 511), $urandom_range(0, 255));
      cx = 0; cy = 0; de = 1'b0;
      for (int i = 0; i < 124; i++) begin
        if (i < 120) begin
          cx = $urandom_range(0, 1023); cy = $urandom_range(0, 1023); de = 1'($urandom_range(0, 1));
        end else de = 1'b0;
        CounterX = 10'(cx); CounterY = 10'(cy); inDisplayArea = de;
        ha[i] = exp_addr(cx, cy); hd[i] = de;
        step;
        if (i >= 2) begin
          n_vec++;
          if (rom_addr !== ha[i-2]) begin n_err++; $display("FAIL rand_rom_addr %0d: got %h expected %h", i, rom_addr, ha[i-2]); end
        end
        if (i >= 4) begin
          n_vec++;
          if (de_out !== hd[i-4] || {vga_r, vga_g, vga_b} !== (hd[i-4] ? ha[i-4][7:0] : 8'h00)) begin
            n_err++; $display("FAIL rand_pixel %0d: got de %b col %h expected de %b col %h", i, de_out,
              {vga_r, vga_g, vga_b}, hd[i-4], hd[i-4] ? ha[i-4][7:0] : 8'h00);
          end
        end
      end
    end
  endtask

  task automatic test_collision;
    int cx, cy;
    logic [9:0] old_a;
    cx = ((504 - act_x + 512) % 512) + X0;
    cy = ((248 - act_y + 256) % 256) + Y0;
    old_a = exp_addr(cx, cy);
    CounterX = 10'(cx); CounterY = 10'(cy); inDisplayArea = 1'b1;
    step;
    map_we = 1'b1; map_waddr = 11'h7FF; map_wdata = 4'd9;
    step;
    map_we = 1'b0;
    step;
    n_vec++;
    if (rom_addr !== old_a || rom_addr[9:6] !== 4'd3) begin n_err++; $display("FAIL collision_old: got %h expected %h", rom_addr, old_a); end
    map_m[2047] = 4'd9;
    step;
    n_vec++;
    if (rom_addr !== exp_addr(cx, cy) || rom_addr[9:6] !== 4'd9) begin
      n_err++; $display("FAIL collision_new: got %h expected %h", rom_addr, exp_addr(cx, cy));
    end
  endtask

  task automatic test_reset_mid;
    CounterX = 10'(X0 + 504); CounterY = 10'(Y0 + 248); inDisplayArea = 1'b1;
    repeat (5) step;
    scroll_valid = 1'b1; scroll_x = 9'd200; scroll_y = 8'd100;
    step;
    scroll_valid = 1'b0;
    reset = 1'b1;
    step;
    n_vec++;
    if ({vga_r, vga_g, vga_b, de_out, rom_addr, scroll_ready} !== 19'd0) begin
      n_err++; $display("FAIL midreset_outputs: got %h expected 0", {vga_r, vga_g, vga_b, de_out, rom_addr, scroll_ready});
    end
    reset = 1'b0; inDisplayArea = 1'b0;
    act_x = 0; act_y = 0;
    #1;
    n_vec++;
    if (scroll_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b expected 1", scroll_ready); end
    repeat (2) step;
    inDisplayArea = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step;
      inDisplayArea = 1'b0;
      n_vec++;
      if (de_out !== (i == 5)) begin n_err++; $display("FAIL midreset_de step %0d: got %b expected %b", i, de_out, i == 5); end
      if (i == 3) begin
        n_vec++;
        if (rom_addr !== exp_addr(X0 + 504, Y0 + 248) || rom_addr[9:6] !== 4'd9) begin
          n_err++; $display("FAIL midreset_map_kept: got %h expected %h", rom_addr, exp_addr(X0 + 504, Y0 + 248));
        end
      end
    end
    vga_v_sync = 1'b1;
    step;
    vga_v_sync = 1'b0;
    CounterX = 10'd63; CounterY = 10'd16;
    repeat (3) step;
    n_vec++;
    if (rom_addr !== exp_addr(63, 16)) begin n_err++; $display("FAIL midreset_pending_dropped: got %h expected %h", rom_addr, exp_addr(63, 16)); end
  endtask

  initial begin
    reset = 1'b1; CounterX = 10'd0; CounterY = 10'd0; inDisplayArea = 1'b0;
    vga_v_sync = 1'b0; scroll_valid = 1'b0; scroll_x = 9'd0; scroll_y = 8'd0;
    map_we = 1'b0; map_waddr = 11'd0; map_wdata = 4'd0;
    test_reset;
    fill_map;
    test_latency;
    test_blank;
    test_handshake;
    test_vsync_coincident;
    test_wrap;
    test_random;
    test_collision;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
